imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Parametrised, registered immediate generator for the decode stage.
- Extracts and extends the immediate from instruction bits [31:7] for all RV32I/RV64I formats, plus CSR zimm and shift-amount forms.
- Holds the result in an output register with a valid/ready handshake and flush, so it can sit between fetch/decode and execute and honour pipeline stalls.
- Flags unsupported format selects.

Parameters:
- DATA_WIDTH, 32, width of the extended immediate; legal values are 32 and 64.
- SRC_WIDTH, 3, width of the format select.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  the instruction fields and format select are valid this cycle.
- in_ready  output  1  the block can accept an input this cycle.
- instr_in  input  25  instruction bits [31:7]; index as instr[31:7].
- imm_src  input  SRC_WIDTH  format select.
- out_valid  output  1  imm_out and imm_illegal hold a valid result.
- out_ready  input  1  the downstream stage consumes the result this cycle.
- flush  input  1  discard any held result and any input presented this cycle.
- imm_out  output  DATA_WIDTH  extended immediate.
- imm_illegal  output  1  the result came from an unsupported select.

Behaviour:
- Reset, sampled at the clk edge while rst_n=0:
  - out_valid=0, imm_out=0, imm_illegal=0.
  - Reset applied mid-transfer drops the held result; no output appears for it after rst_n returns to 1.
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational and gives full throughput.
  - An input is accepted on an edge where in_valid && in_ready && !flush.
  - Latency is 1 cycle: the result is visible on the cycle after acceptance.
- Output register:
  - On accept, load imm_out and imm_illegal and set out_valid=1.
  - If out_ready=1 and there is no accept, clear out_valid. imm_out keeps its last value.
  - If out_ready=0 and out_valid=1, hold imm_out, imm_illegal and out_valid stable, and keep in_ready=0.
  - Simultaneous consume and accept: the new result replaces the old one and out_valid stays 1.
- Flush: takes priority over accept and over hold. On the next edge out_valid=0; imm_out is unchanged.
- Format encoding. sx() means sign-extend from the top bit of the operand to DATA_WIDTH; zx() means zero-extend.
  - 000 I: sx(instr[31:20]).
  - 001 S: sx({instr[31:25], instr[11:7]}).
  - 010 B: sx({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 011 J: sx({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 100 U: sx({instr[31:12], 12'b0}). For DATA_WIDTH=64, bits [63:32] copy instr[31].
  - 101 Z (CSR zimm): zx(instr[19:15]).
  - 110 SH: zx(instr[24:20]) when DATA_WIDTH=32; zx(instr[25:20]) when DATA_WIDTH=64.
  - 111: imm_out=0, imm_illegal=1. The transfer still completes normally through the handshake.
- imm_illegal=0 for all legal selects.
- Extension is purely combinational ahead of the register; the register alone defines the timing.
- in_valid=0 never alters state except through the consume and flush rules above.

Test Plan:
- DATA_WIDTH=32, imm_src=000, instr=0xFFF00093 (addi x1,x0,-1), in_valid=1, out_ready=1 -> next cycle out_valid=1, imm_out=0xFFFFFFFF, imm_illegal=0.
- imm_src=010, instr=0xFE000EE3 (beq -4) -> imm_out=0xFFFFFFFC. Then imm_src=011, instr=0x008000EF (jal x1,+8) -> imm_out=0x00000008, back-to-back with out_valid held at 1.
- DATA_WIDTH=64, imm_src=100, instr=0x800000B7 (lui 0x80000) -> imm_out=0xFFFFFFFF80000000. With imm_src=110 and instr[25:20]=6'b111111 -> imm_out=63.
- Backpressure: accept the I-type above, then hold out_ready=0 for 3 cycles while presenting the jal -> in_ready=0, imm_out stays 0xFFFFFFFF. When out_ready=1, the jal is accepted the same cycle and imm_out=8 one cycle later.
- Flush and reset: assert flush with out_valid=1 and in_valid=1 -> next cycle out_valid=0 and no new result. Set rst_n=0 for one edge mid-stall -> out_valid=0, imm_out=0, imm_illegal=0.
- imm_src=111, any instr -> imm_out=0, imm_illegal=1, out_valid=1. The following legal select returns imm_illegal to 0.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate generator with a valid/ready output stage.
// Extension is combinational; one output register sets the latency and honours stalls.
module imm_gen_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int SRC_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [24:0]           instr_in,
  input  logic [SRC_WIDTH-1:0]  imm_src,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] imm_out,
  output logic                  imm_illegal
);

  localparam logic [SRC_WIDTH-1:0] SRC_I  = SRC_WIDTH'(0);
  localparam logic [SRC_WIDTH-1:0] SRC_S  = SRC_WIDTH'(1);
  localparam logic [SRC_WIDTH-1:0] SRC_B  = SRC_WIDTH'(2);
  localparam logic [SRC_WIDTH-1:0] SRC_J  = SRC_WIDTH'(3);
  localparam logic [SRC_WIDTH-1:0] SRC_U  = SRC_WIDTH'(4);
  localparam logic [SRC_WIDTH-1:0] SRC_Z  = SRC_WIDTH'(5);
  localparam logic [SRC_WIDTH-1:0] SRC_SH = SRC_WIDTH'(6);

  // Keep architectural bit numbering so the field slices read like the ISA manual.
  logic [31:7] ins;
  assign ins = instr_in;

  logic [31:0]           val32;
  logic                  sext;
  logic                  illegal_next;
  logic [DATA_WIDTH-1:0] imm_next;
  logic [31:0]           shamt32;

  // RV64 shifts take a 6-bit amount; RV32 only 5 bits.
  generate
    if (DATA_WIDTH > 32) begin : g_sh64
      assign shamt32 = {26'b0, ins[25:20]};
    end else begin : g_sh32
      assign shamt32 = {27'b0, ins[24:20]};
    end
  endgenerate

  always_comb begin
    val32        = 32'b0;
    sext         = 1'b0;
    illegal_next = 1'b0;
    case (imm_src)
      SRC_I: begin
        val32 = {{20{ins[31]}}, ins[31:20]};
        sext  = 1'b1;
      end
      SRC_S: begin
        val32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        sext  = 1'b1;
      end
      SRC_B: begin
        val32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        sext  = 1'b1;
      end
      SRC_J: begin
        val32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        sext  = 1'b1;
      end
      SRC_U: begin
        val32 = {ins[31:12], 12'b0};
        sext  = 1'b1;
      end
      SRC_Z: begin
        val32 = {27'b0, ins[19:15]};
      end
      SRC_SH: begin
        val32 = shamt32;
      end
      default: begin
        illegal_next = 1'b1;
      end
    endcase
  end

  // Upper half only exists for RV64; zero-extended forms leave it clear.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_ext
      if (gi < 32) begin : g_low
        assign imm_next[gi] = val32[gi];
      end else begin : g_high
        assign imm_next[gi] = sext & val32[31];
      end
    end
  endgenerate

  logic                  out_valid_reg;
  logic [DATA_WIDTH-1:0] imm_reg;
  logic                  illegal_reg;
  logic                  accept;

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      imm_reg       <= '0;
      illegal_reg   <= 1'b0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      imm_reg       <= imm_next;
      illegal_reg   <= illegal_next;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid   = out_valid_reg;
  assign imm_out     = imm_reg;
  assign imm_illegal = illegal_reg;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one 32-bit and one 64-bit instance share stimulus.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [24:0] instr_in;
  logic [2:0]  imm_src;
  logic        out_ready;
  logic        flush;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32;
  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.DATA_WIDTH(32), .SRC_WIDTH(3)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .instr_in(instr_in), .imm_src(imm_src), .out_valid(out_valid32),
    .out_ready(out_ready), .flush(flush), .imm_out(imm32), .imm_illegal(ill32)
  );

  imm_gen_pipe #(.DATA_WIDTH(64), .SRC_WIDTH(3)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .instr_in(instr_in), .imm_src(imm_src), .out_valid(out_valid64),
    .out_ready(out_ready), .flush(flush), .imm_out(imm64), .imm_illegal(ill64)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] src, input logic [31:0] word);
    in_valid = 1'b1;
    imm_src  = src;
    instr_in = word[31:7];
  endtask

  task automatic chk32(input string name, input logic v, input logic [31:0] imm, input logic il);
    checks++;
    if (out_valid32 !== v || imm32 !== imm || ill32 !== il) begin
      errors++;
      $display("FAIL %s: got valid=%0b imm=%h ill=%0b, want valid=%0b imm=%h ill=%0b",
               name, out_valid32, imm32, ill32, v, imm, il);
    end else
      $display("ok   %s: valid=%0b imm=%h ill=%0b", name, out_valid32, imm32, ill32);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    imm_src = 3'd0; instr_in = '0;
    tick; tick;
    chk32("reset32", 1'b0, 32'h0, 1'b0);
    checks++;
    if (out_valid64 !== 1'b0 || imm64 !== 64'h0 || ill64 !== 1'b0) begin
      errors++;
      $display("FAIL reset64: got valid=%0b imm=%h ill=%0b, want 0/0/0", out_valid64, imm64, ill64);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_itype;
    drive(3'b000, 32'hFFF00093);
    tick;
    chk32("itype_addi_m1", 1'b1, 32'hFFFFFFFF, 1'b0);
    checks++;
    if (imm64 !== 64'hFFFFFFFF_FFFFFFFF) begin
      errors++;
      $display("FAIL itype64: got %h want ffffffffffffffff", imm64);
    end
    drive(3'b001, 32'hFE000C23);
    tick;
    chk32("stype_m8", 1'b1, 32'hFFFFFFF8, 1'b0);
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    drive(3'b010, 32'hFE000EE3);
    tick;
    chk32("btype_m4", 1'b1, 32'hFFFFFFFC, 1'b0);
    drive(3'b011, 32'h008000EF);
    tick;
    chk32("jtype_p8", 1'b1, 32'h00000008, 1'b0);
    in_valid = 1'b0;
    tick;
    chk32("drain_keeps_imm", 1'b0, 32'h00000008, 1'b0);
  endtask

  task automatic test_rv64;
    drive(3'b100, 32'h800000B7);
    tick;
    checks++;
    if (imm64 !== 64'hFFFFFFFF_80000000 || out_valid64 !== 1'b1) begin
      errors++;
      $display("FAIL utype64: got %h valid=%0b want ffffffff80000000 valid=1", imm64, out_valid64);
    end else
      $display("ok   utype64: imm=%h", imm64);
    chk32("utype32", 1'b1, 32'h80000000, 1'b0);
    drive(3'b110, 32'h03F00013);
    tick;
    checks++;
    if (imm64 !== 64'd63 || ill64 !== 1'b0) begin
      errors++;
      $display("FAIL shamt64: got %h ill=%0b want 3f ill=0", imm64, ill64);
    end else
      $display("ok   shamt64: imm=%h", imm64);
    chk32("shamt32", 1'b1, 32'd31, 1'b0);
    drive(3'b101, 32'hFFFA8073);
    tick;
    chk32("zimm", 1'b1, 32'd21, 1'b0);
    checks++;
    if (imm64 !== 64'd21) begin
      errors++;
      $display("FAIL zimm64: got %h want 15", imm64);
    end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b1;
    drive(3'b000, 32'hFFF00093);
    tick;
    chk32("bp_accept_i", 1'b1, 32'hFFFFFFFF, 1'b0);
    out_ready = 1'b0;
    drive(3'b011, 32'h008000EF);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready32 !== 1'b0) begin
        errors++;
        $display("FAIL bp_in_ready cycle %0d: got %0b want 0", i, in_ready32);
      end
      tick;
      chk32("bp_hold", 1'b1, 32'hFFFFFFFF, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready32 !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %0b want 1", in_ready32);
    end
    tick;
    chk32("bp_release_jal", 1'b1, 32'h00000008, 1'b0);
  endtask

  task automatic test_flush_reset;
    out_ready = 1'b1;
    drive(3'b000, 32'hFFF00093);
    flush = 1'b1;
    tick;
    chk32("flush_drops", 1'b0, 32'h00000008, 1'b0);
    flush = 1'b0;
    tick;
    chk32("flush_then_accept", 1'b1, 32'hFFFFFFFF, 1'b0);
    out_ready = 1'b0;
    drive(3'b011, 32'h008000EF);
    tick;
    chk32("stall_before_reset", 1'b1, 32'hFFFFFFFF, 1'b0);
    rst_n = 1'b0;
    tick;
    chk32("reset_mid_stall", 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    chk32("no_ghost_after_reset", 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_illegal;
    out_ready = 1'b1;
    drive(3'b111, 32'hDEADBEEF);
    tick;
    chk32("illegal_sel", 1'b1, 32'h0, 1'b1);
    checks++;
    if (ill64 !== 1'b1 || imm64 !== 64'h0) begin
      errors++;
      $display("FAIL illegal64: got imm=%h ill=%0b want 0/1", imm64, ill64);
    end
    drive(3'b000, 32'hFFF00093);
    tick;
    chk32("illegal_clears", 1'b1, 32'hFFFFFFFF, 1'b0);
    in_valid = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_itype;
    test_back_to_back;
    test_rv64;
    test_backpressure;
    test_flush_reset;
    test_illegal;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
